// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared FIFO adapter types
// Occupancy encoding shared by the read- and write-side FIFO adapters.
package fifo_pkg;

  typedef enum logic [1:0] {OCC_ZERO, OCC_ONE, OCC_TWO} occ_t;

endpackage

// File: rtl/fifo_rd_stream_m.sv
// rtl/fifo_rd_stream_m.sv - FWFT FIFO read side to registered valid/ready stream
// Entry 0 plus a skid entry keep pop independent of m_ready.
module fifo_rd_stream_m
  import fifo_pkg::*;
#(
  parameter type DATA_ITEM_TYPE = logic,
  parameter int  CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  DATA_ITEM_TYPE    head,
  input  logic             empty,
  input  logic             rd_rst_busy,
  output logic             pop,
  input  logic             flush,
  output DATA_ITEM_TYPE    m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [CNT_W-1:0] word_cnt
);

  occ_t             r_occ;
  occ_t             w_occ_nxt;
  DATA_ITEM_TYPE    r_entry0;
  DATA_ITEM_TYPE    r_skid;
  DATA_ITEM_TYPE    w_entry0_nxt;
  DATA_ITEM_TYPE    w_skid_nxt;
  logic             r_valid;
  logic [CNT_W-1:0] r_word_cnt;
  logic             w_pop;
  logic             w_xfer;

  assign w_pop  = !rst && !flush && !empty && !rd_rst_busy && (r_occ != OCC_TWO);
  assign w_xfer = r_valid && m_ready;

  always_comb begin
    w_occ_nxt    = r_occ;
    w_entry0_nxt = r_entry0;
    w_skid_nxt   = r_skid;
    unique case (r_occ)
      OCC_ZERO: begin
        if (w_pop) begin
          w_entry0_nxt = head;
          w_occ_nxt    = OCC_ONE;
        end
      end
      OCC_ONE: begin
        if (w_pop && !w_xfer) begin
          w_skid_nxt = head;
          w_occ_nxt  = OCC_TWO;
        end else if (w_pop && w_xfer) begin
          w_entry0_nxt = head;
        end else if (w_xfer) begin
          w_occ_nxt = OCC_ZERO;
        end
      end
      OCC_TWO: begin
        if (w_xfer) begin
          w_entry0_nxt = r_skid;
          w_occ_nxt    = OCC_ONE;
        end
      end
      default: w_occ_nxt = OCC_ZERO;
    endcase
    // flush overrides everything; a same-cycle transfer is still counted below
    if (flush) begin
      w_occ_nxt = OCC_ZERO;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_occ      <= OCC_ZERO;
      r_entry0   <= '0;
      r_skid     <= '0;
      r_valid    <= 1'b0;
      r_word_cnt <= '0;
    end else begin
      r_occ    <= w_occ_nxt;
      r_entry0 <= w_entry0_nxt;
      r_skid   <= w_skid_nxt;
      r_valid  <= (w_occ_nxt != OCC_ZERO);
      if (w_xfer) begin
        r_word_cnt <= r_word_cnt + CNT_W'(1);
      end
    end
  end

  assign pop      = w_pop;
  assign m_data   = r_entry0;
  assign m_valid  = r_valid;
  assign word_cnt = r_word_cnt;

  a_no_pop_empty: assert property (@(posedge clk) disable iff (rst) pop |-> !empty);
  a_hold_stable:  assert property (@(posedge clk) disable iff (rst)
                    (m_valid && !m_ready && !flush) |=> (m_valid && $stable(m_data)));
  a_no_pop_two:   assert property (@(posedge clk) disable iff (rst) pop |-> (r_occ != OCC_TWO));

endmodule

// File: tb/tb_fifo_rd_stream_m.sv
// tb/tb_fifo_rd_stream_m.sv - bench for fifo_rd_stream_m
// A queue-level model of the two-word buffer predicts pop, m_valid, m_data and word_cnt.
module tb_fifo_rd_stream_m;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    head;
  logic          empty;
  logic          rd_rst_busy;
  logic          pop;
  logic          flush;
  logic [7:0]    m_data;
  logic          m_valid;
  logic          m_ready;
  logic [CW-1:0] word_cnt;

  int total = 0;
  int bad   = 0;
  int mc    = 0;
  int npop  = 0;
  bit known = 1'b0;

  logic [7:0] fq[$];
  logic [7:0] mb[$];
  logic [7:0] got[$];
  logic [7:0] ex[$];

  fifo_rd_stream_m #(
    .DATA_ITEM_TYPE(logic [7:0]),
    .CNT_W         (CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .head       (head),
    .empty      (empty),
    .rd_rst_busy(rd_rst_busy),
    .pop        (pop),
    .flush      (flush),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .word_cnt   (word_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic chk_seq(input string tag);
    chk({tag, "_len"}, 32'(got.size()), 32'(ex.size()));
    for (int i = 0; i < ex.size() && i < got.size(); i++) begin
      chk(tag, 32'(got[i]), 32'(ex[i]));
    end
  endtask

  // One clock: drive at negedge, check at negedge+1, advance model at posedge.
  task automatic step(input logic rdy, input logic fl, input logic busy, input logic rs);
    logic exp_pop;
    logic exp_valid;
    logic obs_pop;
    rst         = rs;
    m_ready     = rdy;
    flush       = fl;
    rd_rst_busy = busy;
    empty       = (fq.size() == 0);
    head        = empty ? 8'h00 : fq[0];
    #1;
    exp_valid = (mb.size() > 0);
    exp_pop   = !rs && !fl && !empty && !busy && (mb.size() < 2);
    obs_pop   = pop;
    chk("pop", 32'(obs_pop), 32'(exp_pop));
    if (known) begin
      chk("m_valid", 32'(m_valid), 32'(exp_valid));
      if (exp_valid) chk("m_data", 32'(m_data), 32'(mb[0]));
      chk("word_cnt", 32'(word_cnt), 32'(mc % (1 << CW)));
    end
    if (m_valid === 1'b1 && rdy && !rs) got.push_back(m_data);
    @(posedge clk);
    if (rs) begin
      mb.delete();
      mc    = 0;
      known = 1'b1;
    end else begin
      if (exp_valid && rdy) begin
        void'(mb.pop_front());
        mc++;
      end
      if (exp_pop) mb.push_back(fq[0]);
      if (fl) mb.delete();
    end
    if (obs_pop === 1'b1) begin
      npop++;
      if (fq.size() > 0) void'(fq.pop_front());
    end
    @(negedge clk);
  endtask

  task automatic reset_dut();
    fq.delete();
    step(1'b0, 1'b0, 1'b0, 1'b1);
    got.delete();
    npop = 0;
  endtask

  task automatic load_seq(input int first, input int last);
    ex.delete();
    for (int i = first; i <= last; i++) begin
      fq.push_back(8'(i));
      ex.push_back(8'(i));
    end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; m_ready = 1'b0; rd_rst_busy = 1'b0;
    empty = 1'b1; head = 8'h00;
    @(negedge clk);

    reset_dut();
    chk("rst_valid", 32'(m_valid), 32'd0);
    chk("rst_data", 32'(m_data), 32'd0);
    chk("rst_cnt", 32'(word_cnt), 32'd0);

    // streaming at full rate
    load_seq(1, 8);
    repeat (10) step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("t1_pops", 32'(npop), 32'd8);
    chk("t1_cnt", 32'(word_cnt), 32'd8);
    chk_seq("t1_order");

    // backpressure fills both entries
    reset_dut();
    load_seq(1, 8);
    repeat (10) step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("t2_pops", 32'(npop), 32'd2);
    chk("t2_valid", 32'(m_valid), 32'd1);
    chk("t2_hold", 32'(m_data), 32'h01);
    repeat (12) step(1'b1, 1'b0, 1'b0, 1'b0);
    chk_seq("t2_order");

    // alternating ready, random payload
    reset_dut();
    ex.delete();
    for (int i = 0; i < 16; i++) begin
      logic [7:0] v;
      v = 8'($urandom);
      fq.push_back(v);
      ex.push_back(v);
    end
    for (int i = 0; i < 48; i++) step((i % 2) == 0, 1'b0, 1'b0, 1'b0);
    chk_seq("t3_order");

    // flush while holding two words
    reset_dut();
    load_seq(5, 8);
    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("t4_pops", 32'(npop), 32'd2);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    chk("t4_valid", 32'(m_valid), 32'd0);
    got.delete();
    repeat (4) step(1'b1, 1'b0, 1'b0, 1'b0);
    ex.delete();
    ex.push_back(8'h07);
    ex.push_back(8'h08);
    chk_seq("t4_order");

    // read-side reset busy: buffered word drains, no pops
    reset_dut();
    fq.push_back(8'h10);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    fq.push_back(8'h21); fq.push_back(8'h22); fq.push_back(8'h23);
    npop = 0;
    repeat (3) step(1'b1, 1'b0, 1'b1, 1'b0);
    chk("t5_pops", 32'(npop), 32'd0);
    chk("t5_drained", 32'(m_valid), 32'd0);
    repeat (6) step(1'b1, 1'b0, 1'b0, 1'b0);
    ex.delete();
    ex.push_back(8'h10); ex.push_back(8'h21); ex.push_back(8'h22); ex.push_back(8'h23);
    chk_seq("t5_order");

    // counter wrap, then reset mid-stream
    reset_dut();
    load_seq(1, 20);
    for (int i = 0; i < 60 && mc < 17; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("t6_wrap", 32'(word_cnt), 32'd1);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    chk("t6_rst_valid", 32'(m_valid), 32'd0);
    chk("t6_rst_cnt", 32'(word_cnt), 32'd0);
    repeat (4) step(1'b1, 1'b0, 1'b0, 1'b0);

    // random traffic against the model
    reset_dut();
    for (int i = 0; i < 400; i++) begin
      if (fq.size() < 6 && $urandom_range(0, 1) == 1) fq.push_back(8'($urandom));
      step($urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0,
           $urandom_range(0, 9) == 0, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
